// File: rtl/maxpool_2x2_stream.sv
`default_nettype none
// ============================================================================
// Module   : maxpool_2x2_stream
// Brief    : Streaming 2x2 stride-2 signed max-pool over a raster pixel stream,
//            using a half-width line buffer for the even-row pair maxima.
// Revision : 1.0 - initial release
// ============================================================================
module maxpool_2x2_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              dout_valid,
    output logic [DATA_W-1:0] dout,
    output logic              frame_done
);

    localparam int c_COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int c_ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int c_HALF  = IMG_W / 2;
    localparam int c_IDX_W = (c_HALF > 1) ? $clog2(c_HALF) : 1;

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [DATA_W-1:0]  r_h;
    logic [DATA_W-1:0]  r_lb [c_HALF];
    logic [DATA_W-1:0]  r_dout;
    logic               r_dv;
    logic               r_fd;

    logic               w_col_last;
    logic               w_row_last;
    logic               w_emit;
    logic [c_IDX_W-1:0] w_idx;
    logic [DATA_W-1:0]  w_pair;
    logic [DATA_W-1:0]  w_lb_rd;
    logic [DATA_W-1:0]  w_pool;

    assign w_col_last = (r_col == c_COL_W'(IMG_W - 1));
    assign w_row_last = (r_row == c_ROW_W'(IMG_H - 1));
    // Odd column of an odd row closes a 2x2 window.
    assign w_emit     = r_col[0] & r_row[0];
    assign w_idx      = c_IDX_W'(r_col >> 1);
    assign w_lb_rd    = r_lb[w_idx];
    assign w_pair     = ($signed(r_h) > $signed(din)) ? r_h : din;
    assign w_pool     = ($signed(w_lb_rd) > $signed(w_pair)) ? w_lb_rd : w_pair;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_row  <= '0;
            r_dout <= '0;
            r_dv   <= 1'b0;
            r_fd   <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_fd <= 1'b0;
            if (din_valid) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (w_emit) begin
                    r_dout <= w_pool;
                    r_dv   <= 1'b1;
                    r_fd   <= w_row_last & w_col_last;
                end
            end
        end
    end

    // Pixel datapath storage needs no reset: every slot is written before use.
    always_ff @(posedge clk) begin
        if (din_valid && !r_col[0]) begin
            r_h <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (din_valid && r_col[0] && !r_row[0]) begin
            r_lb[w_idx] <= w_pair;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dv;
    assign frame_done = r_fd;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_2x2_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxpool_2x2_stream
// Brief    : Self-checking bench; 4x4 and 28x28 instances against a window-max model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_2x2_stream;

    typedef struct {
        int v;
        int t;
        bit fd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, b_valid;
    logic [15:0] s_din, b_din;
    logic        s_dv, b_dv;
    logic [15:0] s_dout, b_dout;
    logic        s_fd, b_fd;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int   s_px[$], s_acc[$], b_px[$], b_acc[$];
    obs_t s_obs[$], b_obs[$];
    int   s_lone = 0, b_lone = 0, s_hold = 0, b_hold = 0;
    logic [15:0] s_last, b_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    maxpool_2x2_stream #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_small (
        .clk(clk), .rst_n(rst_n), .din_valid(s_valid), .din(s_din),
        .dout_valid(s_dv), .dout(s_dout), .frame_done(s_fd)
    );

    maxpool_2x2_stream #(.DATA_W(16), .IMG_W(28), .IMG_H(28)) u_big (
        .clk(clk), .rst_n(rst_n), .din_valid(b_valid), .din(b_din),
        .dout_valid(b_dv), .dout(b_dout), .frame_done(b_fd)
    );

    // Output monitor: records every pulse with its cycle, and flags stray frame_done / dout drift.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            s_last = '0;
            b_last = '0;
        end else begin
            if (s_dv) begin
                s_obs.push_back('{int'($signed(s_dout)), cyc, s_fd});
                s_last = s_dout;
            end else begin
                if (s_fd) s_lone++;
                if (s_dout !== s_last) s_hold++;
            end
            if (b_dv) begin
                b_obs.push_back('{int'($signed(b_dout)), cyc, b_fd});
                b_last = b_dout;
            end else begin
                if (b_fd) b_lone++;
                if (b_dout !== b_last) b_hold++;
            end
        end
    end

    task automatic feed(input bit big, input int v, input bit bub);
        if (bub) begin
            @(negedge clk);
            if (big) begin b_valid = 1'b0; b_din = 16'h7fff; end
            else     begin s_valid = 1'b0; s_din = 16'h7fff; end
        end
        @(negedge clk);
        if (big) begin
            b_valid = 1'b1; b_din = v[15:0];
            b_px.push_back(v); b_acc.push_back(cyc + 1);
        end else begin
            s_valid = 1'b1; s_din = v[15:0];
            s_px.push_back(v); s_acc.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b0; s_din = 16'h7fff;
            b_valid = 1'b0; b_din = 16'h7fff;
        end
    endtask

    task automatic clear_logs();
        s_px.delete(); s_acc.delete(); s_obs.delete();
        b_px.delete(); b_acc.delete(); b_obs.delete();
        s_lone = 0; b_lone = 0; s_hold = 0; b_hold = 0;
    endtask

    // Reference: each output is the max of a 2x2 window, visible in the cycle after
    // the window's last pixel is sampled; frame_done on the final window of each frame.
    task automatic check_stream(input string name, input bit big);
        int   w, h, fsz, nfr, base, idx, m, n;
        int   px[$], acc[$];
        obs_t obs[$];
        obs_t exp[$];
        int   lone, hold;
        w = big ? 28 : 4;
        h = big ? 28 : 4;
        if (big) begin px = b_px; acc = b_acc; obs = b_obs; lone = b_lone; hold = b_hold; end
        else     begin px = s_px; acc = s_acc; obs = s_obs; lone = s_lone; hold = s_hold; end
        fsz = w * h;
        nfr = px.size() / fsz;
        for (int f = 0; f < nfr; f++) begin
            for (int r = 0; r < h / 2; r++) begin
                for (int c = 0; c < w / 2; c++) begin
                    base = f * fsz;
                    idx  = base + 2 * r * w + 2 * c;
                    m = px[idx];
                    if (px[idx + 1] > m)     m = px[idx + 1];
                    if (px[idx + w] > m)     m = px[idx + w];
                    if (px[idx + w + 1] > m) m = px[idx + w + 1];
                    exp.push_back('{m, acc[idx + w + 1], (r == h / 2 - 1) && (c == w / 2 - 1)});
                end
            end
        end
        checks++;
        if (obs.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s count: got %0d outputs, expected %0d", name, obs.size(), exp.size());
        end
        n = (obs.size() < exp.size()) ? obs.size() : exp.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs[i].v !== exp[i].v) begin
                errors++;
                $display("FAIL %s value[%0d]: got %0d, expected %0d", name, i, obs[i].v, exp[i].v);
            end
            checks++;
            if (obs[i].t !== exp[i].t || obs[i].fd !== exp[i].fd) begin
                errors++;
                $display("FAIL %s timing[%0d]: got cyc %0d fd %0b, expected cyc %0d fd %0b",
                         name, i, obs[i].t, obs[i].fd, exp[i].t, exp[i].fd);
            end
        end
        checks++;
        if (lone !== 0 || hold !== 0) begin
            errors++;
            $display("FAIL %s idle: stray frame_done %0d, dout changes without valid %0d, expected 0/0",
                     name, lone, hold);
        end
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        checks++;
        if ({s_dv, s_fd, s_dout} !== 18'd0 || {b_dv, b_fd, b_dout} !== 18'd0) begin
            errors++;
            $display("FAIL reset: small dv/fd/dout %b/%b/%0h big %b/%b/%0h, expected all 0",
                     s_dv, s_fd, s_dout, b_dv, b_fd, b_dout);
        end
        rst_n = 1'b1;
        idle(2);
        clear_logs();
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 16; i++) feed(1'b0, i, 1'b0);
        idle(4);
        check_stream("ramp", 1'b0);
    endtask

    task automatic test_negatives();
        for (int i = 0; i < 16; i++) feed(1'b0, -i, 1'b0);
        idle(4);
        check_stream("negatives", 1'b0);
    endtask

    task automatic test_bubbles();
        for (int i = 0; i < 16; i++) feed(1'b0, i, 1'b1);
        idle(4);
        check_stream("bubbles", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) feed(1'b0, i, 1'b0);
        for (int i = 0; i < 16; i++) feed(1'b0, i + 100, 1'b0);
        idle(4);
        check_stream("back_to_back", 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 9; i++) feed(1'b0, i, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_dv, s_fd, s_dout} !== 18'd0) begin
            errors++;
            $display("FAIL reset_async: dv %b fd %b dout %0h, expected 0/0/0", s_dv, s_fd, s_dout);
        end
        idle(2);
        clear_logs();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) feed(1'b0, i, 1'b0);
        idle(4);
        check_stream("after_reset", 1'b0);
    endtask

    task automatic test_default_geometry();
        logic signed [15:0] r;
        for (int i = 0; i < 28 * 28; i++) begin
            r = 16'($urandom);
            feed(1'b1, int'(r), ($urandom_range(0, 3) == 0));
        end
        idle(4);
        check_stream("default_geometry", 1'b1);
    endtask

    initial begin
        s_valid = 1'b0; s_din = '0;
        b_valid = 1'b0; b_din = '0;
        test_reset();
        test_ramp();
        test_negatives();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_frame();
        test_default_geometry();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
